// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the fifo_read_arbiter block.
//
// The arbiter, its output buffer and this package are sized together. The
// ARB_* constants below are the single place where the source count and the
// word width are chosen, and the top-level parameters default to them.
//
// Contents:
//   src_idx_t    - index of one source FIFO
//   arb_entry_t  - one buffered output word tagged with its source
//   rr_result_t  - result of a round-robin scan (found flag + index)
//   rr_next()    - first requesting source strictly after a pointer, wrapping
package fifo_arb_pkg;

    localparam int ARB_DATA_WIDTH = 8;
    localparam int ARB_NUM_SRC    = 4;
    localparam int ARB_MAX_BURST  = 4;
    localparam int ARB_SRC_W      = $clog2(ARB_NUM_SRC);
    localparam int ARB_BURST_W    = $clog2(ARB_MAX_BURST + 1);

    typedef logic [ARB_SRC_W-1:0] src_idx_t;

    typedef struct packed {
        src_idx_t                  src;
        logic [ARB_DATA_WIDTH-1:0] data;
    } arb_entry_t;

    typedef struct packed {
        logic     found;
        src_idx_t idx;
    } rr_result_t;

    // Scan ptr+1, ptr+2, ... ptr+ARB_NUM_SRC (mod ARB_NUM_SRC) and return
    // the first index whose request bit is set. The pointer itself is the
    // last candidate, so it is only picked when nothing else requests.
    function automatic rr_result_t rr_next(input src_idx_t ptr,
                                           input logic [ARB_NUM_SRC-1:0] req_mask);
        rr_result_t r;
        int         cand;
        r = '0;
        for (int k = 1; k <= ARB_NUM_SRC; k++) begin
            cand = (int'(ptr) + k) % ARB_NUM_SRC;
            if (!r.found && req_mask[src_idx_t'(cand)]) begin
                r.found = 1'b1;
                r.idx   = src_idx_t'(cand);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_arb_skid.sv
// fifo_arb_skid
// Two-entry in-order buffer of {src, data} words that feeds the arbiter's
// valid/ready output. Entry 0 is always the head, so the head is a plain
// register and stays stable while it is not popped.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   push         - write push_entry this cycle
//   push_entry   - word captured from the granted source
//   pop          - head is consumed this cycle
//   head         - current head entry (zero after reset)
//   head_valid   - buffer holds at least one entry
//   occupancy    - number of stored entries, 0..2
//
// Push and pop in the same cycle keep the occupancy constant. A push into a
// full buffer without a pop is ignored; the arbiter's issue rule never
// produces one.
module fifo_arb_skid
    import fifo_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  arb_entry_t push_entry,
    input  logic       pop,
    output arb_entry_t head,
    output logic       head_valid,
    output logic [1:0] occupancy
);

    arb_entry_t e0;
    arb_entry_t e1;
    logic       pop_ok;
    logic       push_ok;

    assign pop_ok  = pop && (occupancy != 2'd0);
    assign push_ok = push && ((occupancy != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            e0        <= '0;
            e1        <= '0;
            occupancy <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occupancy == 2'd0) begin
                        e0 <= push_entry;
                    end else begin
                        e1 <= push_entry;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    e0        <= e1;
                    occupancy <= occupancy - 2'd1;
                end
                2'b11: begin
                    // The new word lands behind whatever remains after the pop.
                    if (occupancy == 2'd1) begin
                        e0 <= push_entry;
                    end else begin
                        e0 <= e1;
                        e1 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head       = e0;
    assign head_valid = (occupancy != 2'd0);

endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
// Shares one downstream consumer between NUM_SRC source FIFOs with
// registered read data. At most one read strobe is issued per cycle, chosen
// round-robin with a burst lock of up to MAX_BURST consecutive reads from
// the same source. The word arrives on fifo_dout one cycle after the strobe
// and is captured into a two-entry buffer that drives a valid/ready stream
// tagged with the source index.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   fifo_empty  - per-source empty flags
//   fifo_dout   - per-source registered read data
//   fifo_ren    - per-source read strobes, one-hot or zero, combinational
//   out_valid   - output head valid
//   out_data    - output head data
//   out_src     - source index of the output head
//   out_ready   - consumer accepts the head when high with out_valid
//   busy        - output head valid or a read in flight
//
// Handshake: a word transfers on every cycle where out_valid && out_ready;
// out_data/out_src hold while out_valid && !out_ready.
//
// Parameters default to the fifo_arb_pkg constants and must match them,
// since the buffered entry type and the scan helper are sized there.
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int NUM_SRC    = ARB_NUM_SRC,
    parameter int MAX_BURST  = ARB_MAX_BURST,
    parameter int SRC_W      = $clog2(NUM_SRC),
    parameter int BURST_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC-1:0]                 fifo_empty,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] fifo_dout,
    output logic [NUM_SRC-1:0]                 fifo_ren,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [SRC_W-1:0]                   out_src,
    input  logic                               out_ready,
    output logic                               busy
);

    // Arbitration state. While lock_valid is set, rr_ptr is the locked
    // source: every new grant moves rr_ptr to the granted source.
    src_idx_t             rr_ptr;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 lock_valid;

    // Read pipeline: a strobe in cycle t makes the word visible in t+1.
    logic                 inflight;
    src_idx_t             inflight_src;

    logic [NUM_SRC-1:0]   req;
    logic [1:0]           occupancy;
    logic                 pop;
    logic                 can_issue;
    logic                 lock_hit;
    rr_result_t           scan;
    logic                 issue;
    src_idx_t             grant;
    arb_entry_t           capture;
    arb_entry_t           head;

    assign req = ~fifo_empty;
    assign pop = out_valid && out_ready;

    // Words already committed to the buffer (stored or in flight), less the
    // one leaving this cycle, must leave room for one more.
    assign can_issue = ({1'b0, occupancy} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign lock_hit = lock_valid && req[rr_ptr] && (burst_cnt < BURST_W'(MAX_BURST));

    assign scan  = rr_next(rr_ptr, req);
    assign issue = !rst && can_issue && scan.found;
    assign grant = lock_hit ? rr_ptr : scan.idx;

    always_comb begin
        fifo_ren = '0;
        if (issue) begin
            fifo_ren[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            lock_valid   <= 1'b0;
            inflight     <= 1'b0;
            inflight_src <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_src <= grant;
            end

            if (!scan.found) begin
                // Nothing to read anywhere: drop the lock so the next
                // arrival starts a fresh burst.
                lock_valid <= 1'b0;
                burst_cnt  <= '0;
            end else if (issue) begin
                if (lock_hit) begin
                    burst_cnt <= burst_cnt + BURST_W'(1);
                end else begin
                    // Scan result, including a re-grant of the same source
                    // after its burst ran out: always a new burst of one.
                    rr_ptr     <= grant;
                    burst_cnt  <= BURST_W'(1);
                    lock_valid <= 1'b1;
                end
            end
            // Blocked by a full buffer: lock and counters hold.
        end
    end

    assign capture.src  = inflight_src;
    assign capture.data = fifo_dout[inflight_src];

    fifo_arb_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_entry (capture),
        .pop        (pop),
        .head       (head),
        .head_valid (out_valid),
        .occupancy  (occupancy)
    );

    assign out_data = head.data;
    assign out_src  = head.src;
    assign busy     = out_valid || inflight;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int MB = 4;
  localparam int SW = 2;

  typedef struct {
    bit            out_ready;
    logic [NS-1:0] ren;
    bit            valid;
    bit            chk_data;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    bit            busy;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NS-1:0]         fifo_empty = '1;
  logic [NS-1:0][DW-1:0] fifo_dout = '0;
  logic [NS-1:0]         fifo_ren;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic [SW-1:0]         out_src;
  logic                  out_ready = 1'b0;
  logic                  busy;

  fifo_read_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // ---------------- environment + reference model ----------------
  logic [DW-1:0]      src_q [NS][$];
  logic [SW+DW-1:0]   exp_q [$];
  int                 exp_cyc [$];
  int                 m_ptr, m_cnt;
  bit                 m_lock;
  int                 cyc;
  logic [DW-1:0]      next_data;
  int                 grant_log [$];
  int                 grant_cyc [$];
  int                 errors, checks;
  vec_t               cur_row;
  bit                 row_en;
  vec_t               tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void refresh_empty();
    for (int i = 0; i < NS; i++) fifo_empty[i] = (src_q[i].size() == 0);
  endfunction

  task automatic load_word(input int s, input logic [DW-1:0] v);
    src_q[s].push_back(v);
    refresh_empty();
  endtask

  task automatic load_n(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      src_q[s].push_back(next_data);
      next_data++;
    end
    refresh_empty();
  endtask

  // One clock cycle: check at the falling edge, predict, then apply the
  // source FIFO reads just after the rising edge.
  task automatic step();
    logic [NS-1:0] req, exp_ren, act_ren;
    bit head_ok, acc, can;
    int g;
    @(negedge clk);
    act_ren = fifo_ren;
    req = ~fifo_empty;
    if (row_en) begin
      check("tbl_ren", fifo_ren, cur_row.ren);
      check("tbl_valid", out_valid, cur_row.valid);
      check("tbl_busy", busy, cur_row.busy);
      if (cur_row.chk_data) check("tbl_head", {out_src, out_data}, {cur_row.src, cur_row.data});
    end
    if (rst) begin
      check("ren_in_reset", fifo_ren, '0);
    end else begin
      head_ok = (exp_q.size() > 0) && (exp_cyc[0] + 2 <= cyc);
      check("out_valid", out_valid, head_ok);
      check("busy", busy, head_ok || (exp_cyc.size() > 0 && exp_cyc[$] == cyc - 1));
      if (head_ok) check("out_head", {out_src, out_data}, exp_q[0]);
      acc = head_ok && out_ready;
      can = (exp_q.size() - int'(acc)) < 2;
      exp_ren = '0;
      g = -1;
      if (can && req != 0) begin
        if (m_lock && req[m_ptr] && m_cnt < MB) begin
          g = m_ptr;
          m_cnt++;
        end else begin
          for (int k = 1; k <= NS; k++)
            if (g < 0 && req[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
          m_ptr = g;
          m_cnt = 1;
          m_lock = 1;
        end
        exp_ren[g] = 1'b1;
      end
      if (req == 0) begin
        m_lock = 0;
        m_cnt = 0;
      end
      check("fifo_ren", fifo_ren, exp_ren);
      if (acc) begin
        void'(exp_q.pop_front());
        void'(exp_cyc.pop_front());
      end
      if (g >= 0) begin
        exp_q.push_back({SW'(g), src_q[g][0]});
        exp_cyc.push_back(cyc);
      end
    end
    check("ren_legal", ((act_ren & fifo_empty) == 0) && $onehot0(act_ren), 1);
    check("occupancy_le_2", dut.u_skid.occupancy <= 2, 1);
    for (int i = 0; i < NS; i++)
      if (act_ren[i]) begin
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < NS; i++) src_q[i].delete();
      fifo_dout = '0;
      exp_q.delete();
      exp_cyc.delete();
      m_ptr = 0;
      m_cnt = 0;
      m_lock = 0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (act_ren[i] && src_q[i].size() > 0) fifo_dout[i] = src_q[i].pop_front();
    end
    refresh_empty();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_log();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic check_drained(input string name);
    int left;
    left = exp_q.size();
    for (int i = 0; i < NS; i++) left += src_q[i].size();
    check(name, left, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bool_init();
    errors = 0;
    checks = 0;
    cyc = 0;
    next_data = 8'h30;
    row_en = 0;

    // Single source 2 with 0x11, 0x22: {ready, ren, valid, chk_data, data, src, busy}
    tbl[0] = '{1'b1, 4'b0100, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'b0100, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[2] = '{1'b1, 4'b0000, 1'b1, 1'b1, 8'h11, 2'd2, 1'b1};
    tbl[3] = '{1'b1, 4'b0000, 1'b1, 1'b1, 8'h22, 2'd2, 1'b1};
    tbl[4] = '{1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};

    do_reset();
    do_reset();
    load_word(2, 8'h11);
    load_word(2, 8'h22);
    for (int r = 0; r < 5; r++) begin
      cur_row = tbl[r];
      out_ready = tbl[r].out_ready;
      row_en = 1;
      step();
    end
    row_en = 0;

    // All sources with 8 words, ready high: bursts of four, 1,2,3,0,...
    do_reset();
    for (int s = 0; s < NS; s++) load_n(s, 8);
    out_ready = 1'b1;
    clear_log();
    run(40);
    check("t2_grant_count", grant_log.size(), 32);
    for (int k = 0; k < 32 && k < grant_log.size(); k++) begin
      check("t2_grant_order", grant_log[k], ((k / 4) + 1) % NS);
      check("t2_back_to_back", grant_cyc[k], grant_cyc[0] + k);
    end
    check_drained("t2_drained");

    // Backpressure: ten cycles of ready low issue exactly two reads.
    do_reset();
    for (int s = 0; s < NS; s++) load_n(s, 6);
    out_ready = 1'b0;
    clear_log();
    run(10);
    check("t3_reads_blocked", grant_log.size(), 2);
    out_ready = 1'b1;
    run(40);
    check_drained("t3_drained");

    // Pointer parked at 3, then sources 0 and 3: grants 0,0,3,3.
    do_reset();
    load_n(3, 1);
    run(6);
    load_n(0, 2);
    load_n(3, 2);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant_log.size() == 3 && grant_log[2] == 3 && grant_cyc[2] == cyc - 1)
        check("t4_burst_restart", dut.burst_cnt, 1);
    end
    check("t4_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("t4_grant_order", grant_log[k], (k < 2) ? 0 : 3);

    // Only source 1 with 6 words: re-granted past the burst limit, no bubble.
    do_reset();
    load_n(1, 6);
    clear_log();
    run(12);
    check("t5_grant_count", grant_log.size(), 6);
    for (int k = 0; k < grant_log.size(); k++) begin
      check("t5_grant_src", grant_log[k], 1);
      check("t5_no_bubble", grant_cyc[k], grant_cyc[0] + k);
    end

    // Reset mid-stream with words buffered and a read in flight.
    do_reset();
    for (int s = 0; s < NS; s++) load_n(s, 6);
    out_ready = 1'b1;
    run(5);
    out_ready = 1'b0;
    run(1);
    check("t6_busy_before_rst", busy, 1);
    do_reset();
    cur_row = '{1'b0, 4'b0000, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
    row_en = 1;
    step();
    row_en = 0;
    for (int s = 0; s < NS; s++) load_n(s, 2);
    out_ready = 1'b1;
    clear_log();
    run(12);
    check("t6_first_grant_after_rst", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

    // Random traffic, random backpressure, occasional reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 3) == 0 && src_q[s].size() < 8) load_n(s, $urandom_range(1, 3));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    run(80);
    check_drained("rand_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic void bool_init();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    m_ptr = 0;
    m_cnt = 0;
    m_lock = 0;
  endfunction

endmodule
